// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit (SLL, SRL, SRA, ROL, ROR) with carry, zero and start/busy/done handshake.
// Optional macro SHIFT_MULTIBIT_EN: up to four bit positions per SHIFT cycle instead of one.
module shift_unit_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] b,
    input  logic [2:0]         op,
    output logic [WIDTH-1:0]   out,
    output logic               busy,
    output logic               done,
    output logic               carry,
    output logic               zero,
    output logic               err
);

    localparam int LOG_W = $clog2(WIDTH);
    localparam int CNT_W = LOG_W + 1;
    localparam int CMP_W = (SHAMT_W > CNT_W) ? SHAMT_W : CNT_W;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   out_r;
    logic               carry_r, zero_r, err_r, busy_r, done_r;
    logic [2:0]         op_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [CMP_W-1:0]   b_ext_s;
    logic               op_legal_s;
    logic [CNT_W-1:0]   n_s;
    logic [CNT_W-1:0]   k_s;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [WIDTH-1:0]   sh_val_s;
    logic               sh_carry_s;

    // One single-bit step; result is {bit leaving the word, new value}.
    function automatic logic [WIDTH:0] step1(input logic [WIDTH-1:0] v, input logic [2:0] o);
        logic [WIDTH:0] r;
        case (o)
            OP_SLL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {v[0], 1'b0, v[WIDTH-1:1]};
            OP_SRA:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    assign b_ext_s    = CMP_W'(b);
    assign op_legal_s = (op <= OP_ROR);

    // Effective count: shifts clamp at WIDTH, rotates wrap modulo WIDTH (a power of two).
    always_comb begin
        n_s = {CNT_W{1'b0}};
        if ((op == OP_ROL) || (op == OP_ROR)) begin
            n_s = CNT_W'(b_ext_s[LOG_W-1:0]);
        end else if (b_ext_s >= CMP_W'(WIDTH)) begin
            n_s = CNT_W'(WIDTH);
        end else begin
            n_s = b_ext_s[CNT_W-1:0];
        end
    end

`ifdef SHIFT_MULTIBIT_EN
    // Up to four chained single-bit steps; carry ends as the last bit that left the word.
    always_comb begin
        logic [WIDTH:0] t;
        k_s        = (cnt_r > CNT_W'(4)) ? CNT_W'(4) : cnt_r;
        sh_val_s   = out_r;
        sh_carry_s = carry_r;
        for (int i = 0; i < 4; i++) begin
            if (CNT_W'(i) < k_s) begin
                t          = step1(sh_val_s, op_r);
                sh_carry_s = t[WIDTH];
                sh_val_s   = t[WIDTH-1:0];
            end else begin
                sh_val_s   = sh_val_s;
            end
        end
    end
`else
    // Single-bit step per SHIFT cycle.
    always_comb begin
        logic [WIDTH:0] t;
        k_s        = CNT_W'(1);
        t          = step1(out_r, op_r);
        sh_carry_s = t[WIDTH];
        sh_val_s   = t[WIDTH-1:0];
    end
`endif

    assign cnt_nxt_s = cnt_r - k_s;

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            out_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            op_r    <= OP_SLL;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        out_r   <= a;
                        op_r    <= op;
                        cnt_r   <= n_s;
                        carry_r <= 1'b0;
                        err_r   <= ~op_legal_s;
                        zero_r  <= (a == {WIDTH{1'b0}});
                        busy_r  <= 1'b1;
                        if (!op_legal_s || (n_s == {CNT_W{1'b0}})) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= SHIFT;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    out_r   <= sh_val_s;
                    carry_r <= sh_carry_s;
                    zero_r  <= (sh_val_s == {WIDTH{1'b0}});
                    cnt_r   <= cnt_nxt_s;
                    if (cnt_nxt_s == {CNT_W{1'b0}}) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out   = out_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign carry = carry_r;
    assign zero  = zero_r;
    assign err   = err_r;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq (WIDTH=8), hand-computed expectations.
module tb_shift_unit_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [2:0] op = 3'd0;
    logic [7:0] out;
    logic       busy, done, carry, zero, err;

    int errors = 0;
    int checks = 0;

    shift_unit_seq #(.WIDTH(8), .SHAMT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
        .out(out), .busy(busy), .done(done), .carry(carry), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edges from start edge (inclusive) to done for effective count n.
    function automatic int lat_of(input int n);
`ifdef SHIFT_MULTIBIT_EN
        return (n + 3) / 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] av,
                          input logic [7:0] bv, input logic [7:0] eo, input logic ec,
                          input logic ez, input logic ee, input int elat);
        int lat;
        int busyc;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = ~av; b = 8'd1; op = 3'd1;
        lat = 1;
        busyc = 0;
        while (!done && lat < 40) begin
            if (busy) busyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busyc++;
        check({tag, "_lat"},   lat,   elat);
        check({tag, "_busyc"}, busyc, elat);
        check({tag, "_out"},   out,   eo);
        check({tag, "_carry"}, carry, ec);
        check({tag, "_zero"},  zero,  ez);
        check({tag, "_err"},   err,   ee);
        @(posedge clk); #1;
        check({tag, "_pulse"}, done, 1'b0);
        check({tag, "_idle"},  busy, 1'b0);
        check({tag, "_hold"},  out,  eo);
    endtask

    initial begin
        int dones;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out, 8'h00);
        check("rst_ctl", {busy, done, carry, zero, err}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sll3",   3'd0, 8'h81, 8'd3,   8'h08, 1'b0, 1'b0, 1'b0, lat_of(3));
        run_op("sra2",   3'd2, 8'h90, 8'd2,   8'hE4, 1'b0, 1'b0, 1'b0, lat_of(2));
        run_op("sra9",   3'd2, 8'h90, 8'd9,   8'hFF, 1'b1, 1'b0, 1'b0, lat_of(8));
        run_op("sll200", 3'd0, 8'h81, 8'd200, 8'h00, 1'b1, 1'b1, 1'b0, lat_of(8));
        run_op("srl8",   3'd1, 8'h81, 8'd8,   8'h00, 1'b1, 1'b1, 1'b0, lat_of(8));
        run_op("rol11",  3'd3, 8'h81, 8'd11,  8'h0C, 1'b0, 1'b0, 1'b0, lat_of(3));
        run_op("ror1",   3'd4, 8'h81, 8'd1,   8'hC0, 1'b1, 1'b0, 1'b0, lat_of(1));
        run_op("rol8",   3'd3, 8'hA5, 8'd8,   8'hA5, 1'b0, 1'b0, 1'b0, 1);
        run_op("ror0",   3'd4, 8'h5A, 8'd0,   8'h5A, 1'b0, 1'b0, 1'b0, 1);
        run_op("ill6",   3'd6, 8'h33, 8'd5,   8'h33, 1'b0, 1'b0, 1'b1, 1);
        run_op("sll0v",  3'd0, 8'h00, 8'd1,   8'h00, 1'b0, 1'b1, 1'b0, lat_of(1));

        // Start while busy must be ignored.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 8'hF0; b = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 8'h01; b = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check("busyst_dones", dones, 1);
        check("busyst_out",   out,   8'h0F);
        check("busyst_carry", carry, 1'b0);

        // Reset in the middle of SHIFT aborts the operation.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 8'h81; b = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_out", out, 8'h00);
        check("mid_ctl", {busy, done, carry, zero, err}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("mid_nodone", dones, 0);
        check("mid_idle",   busy,  1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
